// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a synchronous instruction memory, delivers one word
// per clock to decode, and handles stall (skid buffer), branch redirect and HALT.
module instruction_fetch #(
  parameter int          ADDR_WIDTH  = 8,
  parameter logic [19:0] NOP_INSTR   = 20'hA0000,
  parameter logic [3:0]  HALT_OPCODE = 4'b1001
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [19:0]           imem_data,
  output logic [19:0]           instruction,
  output logic                  instruction_valid,
  output logic [ADDR_WIDTH-1:0] pc_out
);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_HALT} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q, pending_pc_q, skid_pc_q, pc_out_q;
  logic                  pending_q, skid_valid_q, valid_q;
  logic [19:0]           skid_data_q, instr_q;

  logic [19:0]           fetch_word;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fetch_halt;

  // The word owed to decode sits in the skid buffer once a stall has caught it,
  // otherwise it is arriving on imem_data this cycle.
  assign fetch_word = skid_valid_q ? skid_data_q : imem_data;
  assign fetch_pc   = skid_valid_q ? skid_pc_q   : pending_pc_q;
  assign fetch_halt = (fetch_word[19:16] == HALT_OPCODE);

  assign imem_addr         = pc_q;
  assign instruction       = instr_q;
  assign instruction_valid = valid_q;
  assign pc_out            = pc_out_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      pc_q         <= '0;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      pc_out_q     <= '0;
    end else if (branch_taken) begin
      state_q      <= S_FILL;
      pc_q         <= branch_target;
      pending_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
    end else begin
      case (state_q)
        // Nothing is owed to decode here, so the issue goes out even under stall;
        // a stall next cycle parks the returning word in the skid buffer.
        S_FILL: begin
          pending_q    <= 1'b1;
          pending_pc_q <= pc_q;
          pc_q         <= pc_q + ADDR_WIDTH'(1);
          state_q      <= S_RUN;
        end
        S_RUN: begin
          if (stall) begin
            if (pending_q && !skid_valid_q) begin
              skid_valid_q <= 1'b1;
              skid_data_q  <= imem_data;
              skid_pc_q    <= pending_pc_q;
            end
          end else begin
            if (pending_q) begin
              instr_q      <= fetch_word;
              valid_q      <= 1'b1;
              pc_out_q     <= fetch_pc;
              skid_valid_q <= 1'b0;
            end
            if (pending_q && fetch_halt) begin
              // The fetch already in flight is dropped and pc stays frozen.
              pending_q <= 1'b0;
              state_q   <= S_HALT;
            end else begin
              pc_q         <= pc_q + ADDR_WIDTH'(1);
              pending_q    <= 1'b1;
              pending_pc_q <= pc_q;
            end
          end
        end
        S_HALT: begin
          if (!stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a word-stream reference model (queue of in-flight
// addresses over a flat memory array) checked every clock, plus directed scenarios.
module tb_instruction_fetch;
  localparam int          AW   = 8;
  localparam logic [19:0] NOP  = 20'hA0000;
  localparam logic [3:0]  HALT = 4'h9;

  logic          clock = 1'b0, reset = 1'b1, stall = 1'b0, branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [AW-1:0] imem_addr, pc_out;
  logic [19:0]   imem_data = '0;
  logic [19:0]   instruction;
  logic          instruction_valid;
  logic [19:0]   mem [256];
  int            tests = 0, fails = 0;

  // reference model state
  logic [AW-1:0] m_npc, m_pc_out;
  logic [19:0]   m_instr;
  bit            m_valid, m_fill, m_halted;
  logic [AW-1:0] m_q [$];

  instruction_fetch #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .instruction(instruction), .instruction_valid(instruction_valid), .pc_out(pc_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) imem_data <= mem[imem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_npc = '0; m_pc_out = '0; m_instr = NOP; m_valid = 0;
    m_fill = 1; m_halted = 0; m_q.delete();
  endtask

  // One clock of the fetch stream: deliver the oldest in-flight word, then issue next.
  task automatic model_edge();
    logic [AW-1:0] a;
    bit stop;
    stop = 0;
    if (branch_taken) begin
      m_npc = branch_target; m_q.delete(); m_fill = 1; m_halted = 0;
      m_valid = 0; m_instr = NOP;
    end else if (m_halted) begin
      if (!stall) begin m_valid = 0; m_instr = NOP; end
    end else begin
      if (!stall && m_q.size() > 0) begin
        a = m_q.pop_front();
        m_instr = mem[a]; m_valid = 1; m_pc_out = a;
        if (mem[a][19:16] == HALT) begin m_halted = 1; m_q.delete(); stop = 1; end
      end
      if (!stop && (!stall || m_fill)) begin m_q.push_back(m_npc); m_npc = m_npc + 1'b1; end
      m_fill = 0;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock); #1;
    model_edge();
    check(tag, {27'd0, instruction, instruction_valid, pc_out, imem_addr},
               {27'd0, m_instr, m_valid, m_pc_out, m_npc});
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [AW-1:0] pc);
    check(tag, {55'd0, instruction_valid, pc_out}, {55'd0, v, pc});
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {27'd0, instruction, instruction_valid, pc_out, imem_addr},
               {27'd0, NOP, 1'b0, 8'h00, 8'h00});
  endtask

  task automatic hold_reset();
    #3 reset = 1'b0;
    #1 check_reset_vals("async_reset");
    @(posedge clock); #1;
  endtask

  task automatic release_reset();
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] op;
    for (int i = 0; i < 256; i++) mem[i] = 20'(i);
    #1 reset = 1'b0;
    #1 check_reset_vals("reset_vals");
    @(posedge clock); #1;
    check_reset_vals("reset_held");
    release_reset();

    // straight-line fetch 0,1,2 then stall while 2 is presented
    step("fill");
    expect_out("fill_invalid", 1'b0, 8'h00);
    step("seq0"); expect_out("seq0_out", 1'b1, 8'h00);
    check("seq0_instr", {44'd0, instruction}, 64'h0);
    step("seq1"); expect_out("seq1_out", 1'b1, 8'h01);
    step("seq2"); expect_out("seq2_out", 1'b1, 8'h02);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall_hold"); expect_out("stall_hold_out", 1'b1, 8'h02);
    end
    stall = 1'b0;
    step("after_stall3"); expect_out("after_stall3_out", 1'b1, 8'h03);
    check("after_stall3_instr", {44'd0, instruction}, 64'h3);
    step("after_stall4"); expect_out("after_stall4_out", 1'b1, 8'h04);

    // branch under stall to 0x40
    stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
    step("br40");
    check("br40_nop", {43'd0, instruction, instruction_valid}, {43'd0, NOP, 1'b0});
    stall = 1'b0; branch_taken = 1'b0;
    step("br40_fill");
    step("br40_arrive"); expect_out("br40_out", 1'b1, 8'h40);

    // branch to 0xFE and wrap
    branch_taken = 1'b1; branch_target = 8'hFE;
    step("brFE");
    branch_taken = 1'b0;
    step("brFE_fill");
    step("wrapFE"); expect_out("wrapFE_out", 1'b1, 8'hFE);
    step("wrapFF"); expect_out("wrapFF_out", 1'b1, 8'hFF);
    step("wrap00"); expect_out("wrap00_out", 1'b1, 8'h00);
    step("wrap01"); expect_out("wrap01_out", 1'b1, 8'h01);

    // HALT word at address 3
    hold_reset();
    mem[3] = 20'h90003;
    release_reset();
    step("h_fill");
    for (int i = 0; i < 4; i++) step("h_seq");
    check("h_latched", {35'd0, instruction, instruction_valid, imem_addr},
                       {35'd0, 20'h90003, 1'b1, 8'h04});
    stall = 1'b1;
    step("h_stalled"); expect_out("h_stall_valid", 1'b1, 8'h03);
    stall = 1'b0;
    step("h_accept");
    for (int i = 0; i < 4; i++) begin
      step("h_idle");
      check("h_frozen", {35'd0, instruction, instruction_valid, imem_addr},
                        {35'd0, NOP, 1'b0, 8'h04});
    end
    branch_taken = 1'b1; branch_target = 8'h00;
    step("h_branch");
    branch_taken = 1'b0;
    step("h_refill");
    step("h_resume"); expect_out("h_resume_out", 1'b1, 8'h00);

    // async reset in the middle of a stall that has filled the skid buffer
    hold_reset();
    mem[3] = 20'h00003;
    release_reset();
    step("s_fill"); step("s_0"); step("s_1");
    stall = 1'b1;
    step("s_stall_a"); step("s_stall_b");
    hold_reset();
    stall = 1'b0;
    release_reset();
    step("s_refill"); expect_out("s_refill_out", 1'b0, 8'h00);
    step("s_restart"); expect_out("s_restart_out", 1'b1, 8'h00);
    step("s_next"); expect_out("s_next_out", 1'b1, 8'h01);

    // randomized traffic over random memory with occasional HALT words
    hold_reset();
    for (int i = 0; i < 256; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == HALT && $urandom_range(0, 3) != 0) op = 4'h0;
      mem[i] = {op, 16'($urandom)};
    end
    release_reset();
    for (int i = 0; i < 400; i++) begin
      step("rand");
      stall         = ($urandom_range(0, 99) < 30);
      branch_taken  = ($urandom_range(0, 99) < 8);
      branch_target = 8'($urandom);
    end
    stall = 1'b0; branch_taken = 1'b0;
    step("rand_tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Parameters
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the instruction-memory address and PC width.
REQ-002 The block SHALL have parameter NOP_INSTR, default 20'hA0000 (opcode 4'b1010), driven on instruction whenever no valid instruction is presented.
REQ-003 The block SHALL have parameter HALT_OPCODE, default 4'b1001, giving the opcode that stops fetching.

Interface
REQ-004 clock  input  1  single rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  decode stage cannot accept an instruction this cycle.
REQ-007 branch_taken  input  1  one-cycle redirect request.
REQ-008 branch_target  input  ADDR_WIDTH  redirect PC, sampled when branch_taken=1.
REQ-009 imem_addr  output  ADDR_WIDTH  synchronous instruction-memory read address.
REQ-010 imem_data  input  20  memory read data for the address presented on the previous clock.
REQ-011 instruction  output  20  registered instruction to decode; opcode in [19:16].
REQ-012 instruction_valid  output  1  instruction holds a real fetched instruction.
REQ-013 pc_out  output  ADDR_WIDTH  address the presented instruction was fetched from.

Function
REQ-014 The block SHALL implement states FILL, RUN and HALT, plus internal registers pc, pending, pending_pc, skid_valid and skid_data.
REQ-015 FILL (first clock after reset release): imem_addr=pc=0, pending<=1, pending_pc<=0, pc<=1, then RUN.
REQ-016 RUN, stall=0, branch_taken=0: imem_addr=pc; pc<=pc+1 (modulo 2^ADDR_WIDTH, e.g. 255 wraps to 0 when ADDR_WIDTH=8); pending<=1; pending_pc<=pc.
REQ-017 When pending=1 and stall=0, instruction<=(skid_valid ? skid_data : imem_data), instruction_valid<=1 and pc_out<=pending_pc (or the skid PC); skid_valid<=0.
REQ-018 While stall=1, instruction, instruction_valid and pc_out SHALL hold, pc SHALL hold, and no new address SHALL be consumed.
REQ-019 On the first stall cycle with pending=1, imem_data and pending_pc SHALL be captured into the skid registers (skid_valid<=1), so no fetched word is lost or duplicated.
REQ-020 Fetch latency SHALL be 2 clocks from address issue to instruction_valid; with stall=0 throughout, one instruction is delivered per clock.
REQ-021 branch_taken=1 (priority over stall and halt) SHALL do all of the following at the next edge: pc<=branch_target; pending<=0; skid_valid<=0; instruction<=NOP_INSTR; instruction_valid<=0; state<=FILL-equivalent issue of branch_target.
REQ-022 After branch_taken, the instruction at branch_target SHALL be valid exactly 2 clocks later if stall=0.
REQ-023 When an instruction with opcode HALT_OPCODE is latched to instruction, the state SHALL go to HALT, any pending fetch SHALL be discarded, and no further addresses SHALL be issued.
REQ-024 In HALT, the HALT instruction SHALL stay valid until accepted (stall=0 for one cycle); afterwards instruction=NOP_INSTR and instruction_valid=0.
REQ-025 HALT SHALL be left only by reset or branch_taken.
REQ-026 imem_addr SHALL be combinational from pc, and SHALL equal pc when no fetch is issued.

Reset
REQ-027 reset=0 SHALL asynchronously set pc=0, pending=0, skid_valid=0, instruction=NOP_INSTR, instruction_valid=0, pc_out=0 and state=FILL, including mid-stall, mid-branch or in HALT.
REQ-028 Reset deassertion SHALL be followed by FILL on the first rising edge, and instruction_valid SHALL first rise on the second edge.

Verification
REQ-029 Memory holds word k = 20'h00000+k at addresses 0..5; release reset with stall=0 -> pc_out 0,1,2,3 on consecutive clocks from the 2nd edge, with instruction 20'h00000..20'h00003 and instruction_valid=1.
REQ-030 Assert stall for 3 cycles while instruction at pc_out=2 is presented -> outputs hold at 2 for those cycles; the next outputs are 3,4 with no gap or duplicate.
REQ-031 branch_taken=1 with branch_target=8'h40 while stall=1 -> next cycle instruction_valid=0 and instruction=20'hA0000; 2 clocks later pc_out=8'h40.
REQ-032 Branch to 8'hFE with stall=0 -> pc_out sequence FE, FF, 00, 01 (wrap).
REQ-033 Word 20'h9xxxx at address 3 -> after pc_out=3 is accepted, instruction_valid=0 permanently and imem_addr frozen; branch_taken to 0 resumes fetch.
REQ-034 Drive reset=0 asynchronously mid-stall with skid_valid=1 -> outputs go to their reset values immediately, without waiting for a clock edge; the post-release sequence restarts at pc_out=0.
